if_id_stage: RTL
================

# if_id_stage

Front end of the 5-stage RV32I pipeline: owns the PC register, the IF/ID pipeline register and the ecall-halt drain sequencer. Consumes `is_stall` from hazard detection and the taken-branch redirect from EX. Supplies the fetch address to instruction memory and the fetched instruction to ID.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- DRAIN_CYCLES, 3, cycles the halt sequencer spends in DRAIN (ecall passes EX, MEM, WB); legal range 1..15

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- is_stall  in  1  hazard stall from ID; hold PC and IF/ID
- flush  in  1  taken branch/jump resolved in EX
- redirect_pc  in  32  target PC, valid when `flush`=1
- inst_mem_dout  in  32  instruction at `current_pc`, combinational read
- halt_req  in  1  ecall with x17==10 decoded in ID, already resolved (not stalled)
- current_pc  out  32  fetch address
- IF_ID_inst  out  32  instruction presented to ID
- IF_ID_pc  out  32  PC of `IF_ID_inst`
- IF_ID_valid  out  1  `IF_ID_inst` is a real instruction (0 = bubble)
- is_halted  out  1  pipeline drained after halting ecall; sticky until reset

## Operation
- Reset values: `current_pc`=RESET_PC, `IF_ID_inst`=32'h0000_0013 (NOP), `IF_ID_pc`=0, `IF_ID_valid`=0, `is_halted`=0, state RUN, drain counter 0.
- Halt FSM states: RUN, DRAIN, HALTED.
- RUN, PC next-value priority: flush → `redirect_pc`; else is_stall → hold; else `current_pc`+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
- RUN, IF/ID priority: flush → NOP, pc 0, valid 0; else is_stall → hold all three; else load `inst_mem_dout`, `current_pc`, valid 1.
- RUN → DRAIN when `halt_req` && `IF_ID_valid` && !flush && !is_stall. Drain counter loaded with DRAIN_CYCLES-1. On that same edge IF/ID loads a bubble and PC holds.
- `halt_req` with flush=1 is ignored (ecall is wrong-path). `halt_req` with is_stall=1 is ignored (re-presented when stall clears).
- DRAIN: PC holds; IF/ID loads bubble every edge; `is_stall` and `flush` ignored. Counter decrements each edge; edge with counter==0 → HALTED.
- HALTED: PC holds, IF/ID holds bubble, `is_halted`=1; only reset leaves.
- Reset asserted in any state returns immediately to reset values; no partial drain is preserved.

## Timing
- `current_pc` and all IF_ID_* outputs are registered; zero combinational path from inputs to outputs.
- Fetch latency: instruction at PC p appears on IF_ID_* one edge after `current_pc`=p, absent stall/flush.
- Stall: each stalled cycle repeats the previous outputs exactly; no instruction lost or duplicated.
- Flush: one edge after flush sampled, `current_pc`=redirect_pc and IF/ID holds a bubble; target instruction reaches IF/ID on the following edge (2-cycle branch penalty).
- Halt: `is_halted` rises DRAIN_CYCLES+1 edges after the edge sampling the qualifying `halt_req` (4 edges at default).
- Flush and stall same cycle: flush wins.

## Configuration
- `IF_ID_STALL_COUNTER_EN`: when defined, adds output `stall_cycles` (out, 32) counting edges in RUN with is_stall=1 && flush=0; resets to 0, saturates at 32'hFFFF_FFFF, frozen in DRAIN/HALTED. When undefined, the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Reset mid-run at PC 0x40, then release → `current_pc`=RESET_PC (0) immediately, IF_ID_inst=0x00000013, IF_ID_valid=0; next edges fetch 0x0, 0x4.
- Straight line from 0, `inst_mem_dout`=0xAAAA0000+pc → after 3 edges `current_pc`=0xC, IF_ID_pc=0x8, IF_ID_inst=0xAAAA0008, valid=1.
- is_stall high 2 cycles with PC 0x10 → `current_pc` stays 0x10, IF_ID_pc stays 0xC for both cycles; then resumes 0x14.
- flush and is_stall together, redirect_pc=0x100 → next edge `current_pc`=0x100, IF_ID_valid=0; following edge IF_ID_pc=0x100.
- halt_req with IF_ID_valid=1 at PC 0x20, flush=0 → DRAIN for 3 cycles ignoring a flush pulse, `is_halted`=1 on 4th edge, `current_pc` frozen at 0x20; halt_req coincident with flush → ignored, no halt.
- With `IF_ID_STALL_COUNTER_EN`: 5 stall cycles, 1 of them with flush → `stall_cycles`=4.

Source files
------------

// File: rtl/if_id_stage.sv
// ----------------------------------------------------------------------------
// if_id_stage
//   Front end of the 5-stage RV32I pipeline. It holds the PC register, the
//   IF/ID pipeline register and the ecall-halt drain sequencer
//   (RUN -> DRAIN -> HALTED).
//
// Parameters
//   RESET_PC      PC loaded on reset
//   DRAIN_CYCLES  cycles spent in DRAIN before HALTED (1..15)
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   is_stall       hazard stall: hold PC and IF/ID
//   flush          taken branch/jump from EX: redirect PC, bubble IF/ID
//   redirect_pc    branch/jump target, valid while flush=1
//   inst_mem_dout  instruction at current_pc (combinational memory read)
//   halt_req       halting ecall decoded in ID
//   current_pc     fetch address
//   IF_ID_inst     instruction presented to ID
//   IF_ID_pc       PC of IF_ID_inst
//   IF_ID_valid    IF_ID_inst is real (0 = bubble)
//   is_halted      pipeline drained after halting ecall; sticky until reset
//   stall_cycles   (IF_ID_STALL_COUNTER_EN only) saturating count of edges
//                  in RUN with is_stall=1 and flush=0
//
// Optional feature macro: IF_ID_STALL_COUNTER_EN
// ----------------------------------------------------------------------------
module if_id_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] inst_mem_dout,
  input  logic        halt_req,
  output logic [31:0] current_pc,
  output logic [31:0] IF_ID_inst,
  output logic [31:0] IF_ID_pc,
  output logic        IF_ID_valid,
`ifdef IF_ID_STALL_COUNTER_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        is_halted
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [31:0] pc_q,      pc_d;
  logic [31:0] inst_q,    inst_d;
  logic [31:0] id_pc_q,   id_pc_d;
  logic        valid_q,   valid_d;
  logic [1:0]  state_q,   state_d;
  logic [3:0]  drain_q,   drain_d;

  // NOTE: every variable gets a default at the top of the always_comb so no
  // path through the case statement can leave it unassigned (no latch).
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    id_pc_d = id_pc_q;
    valid_d = valid_q;
    state_d = state_q;
    drain_d = drain_q;

    case (state_q)
      ST_RUN: begin
        if (flush) begin
          pc_d    = redirect_pc;
          inst_d  = NOP;
          id_pc_d = 32'h0;
          valid_d = 1'b0;
        end else if (is_stall) begin
          // hold everything; the stalled instruction is re-presented
        end else if (halt_req && valid_q) begin
          // ecall is committed to halting: stop fetching, start the drain
          state_d = ST_DRAIN;
          drain_d = 4'(DRAIN_CYCLES - 1);
          inst_d  = NOP;
          id_pc_d = 32'h0;
          valid_d = 1'b0;
        end else begin
          pc_d    = pc_q + 32'd4;
          inst_d  = inst_mem_dout;
          id_pc_d = pc_q;
          valid_d = 1'b1;
        end
      end

      ST_DRAIN: begin
        // stall/flush are ignored: nothing younger than the ecall survives
        inst_d  = NOP;
        id_pc_d = 32'h0;
        valid_d = 1'b0;
        if (drain_q == 4'd0) state_d = ST_HALTED;
        else                 drain_d = drain_q - 4'd1;
      end

      ST_HALTED: begin
        inst_d  = NOP;
        id_pc_d = 32'h0;
        valid_d = 1'b0;
      end

      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP;
      id_pc_q <= 32'h0;
      valid_q <= 1'b0;
      state_q <= ST_RUN;
      drain_q <= 4'd0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      id_pc_q <= id_pc_d;
      valid_q <= valid_d;
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  assign current_pc  = pc_q;
  assign IF_ID_inst  = inst_q;
  assign IF_ID_pc    = id_pc_q;
  assign IF_ID_valid = valid_q;
  assign is_halted   = (state_q == ST_HALTED);

`ifdef IF_ID_STALL_COUNTER_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_RUN && is_stall && !flush && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= 32'h0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
